obstacle_spawn_scheduler: RTL and testbench

Schedules obstacle spawns for the dino game. After each spawn it loads a pseudo-random gap, counts that gap down in frame ticks, then presents a spawn request to the obstacle renderer with a valid/ready handshake. Higher difficulty shortens the random part of the gap. The block sits between the frame-timing logic (which supplies `game_tick`) and the obstacle position/sprite logic (which consumes spawns).

---
 rtl/dino_pkg.sv | 26 ++
 rtl/lfsr8_galois.sv | 30 +++
 rtl/obstacle_spawn_scheduler.sv | 124 ++++++++++++
 tb/tb_obstacle_spawn_scheduler.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// dino_pkg: shared types and constants for the dino-game obstacle logic.
//   spawn_state_t  - obstacle spawn scheduler FSM states
//   LFSR_TAPS      - Galois feedback mask for the 8-bit obstacle LFSR
//   TYPE_*         - spawn_type encodings seen by the obstacle renderer
//   lfsr_next()    - one Galois LFSR step
package dino_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COUNT = 2'd2,
    ST_SPAWN = 2'd3
  } spawn_state_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam logic [1:0] TYPE_CACTUS_SMALL = 2'd0;
  localparam logic [1:0] TYPE_CACTUS_LARGE = 2'd1;
  localparam logic [1:0] TYPE_BIRD_LOW     = 2'd2;
  localparam logic [1:0] TYPE_BIRD_HIGH    = 2'd3;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/lfsr8_galois.sv
// lfsr8_galois: 8-bit Galois LFSR, steps once per cycle with adv high.
//   clk   - clock
//   rst_n - async active-low reset, loads seed (0 is replaced by 8'h01)
//   adv   - advance enable
//   seed  - reset value (expected to be a constant tie-off)
//   q     - current LFSR state
module lfsr8_galois
  import dino_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] r_q;
  logic [7:0] w_seed;

  // An all-zero state would lock the LFSR up forever.
  assign w_seed = (seed == 8'h00) ? 8'h01 : seed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_q <= w_seed;
    else if (adv) r_q <= lfsr_next(r_q);
  end

  assign q = r_q;

endmodule

// File: rtl/obstacle_spawn_scheduler.sv
// obstacle_spawn_scheduler: after each spawn, loads a pseudo-random gap,
// counts it down in frame ticks, then raises a spawn request held until
// the obstacle renderer accepts it.
//   clk           - clock
//   rst_n         - async active-low reset
//   game_tick     - one-cycle pulse per frame
//   run           - game running; low aborts the schedule back to IDLE
//   speed         - difficulty 0..3, shifts the random part of the gap down
//   spawn_ready   - consumer accepts a spawn
//   spawn_valid   - spawn request (registered, held until accepted)
//   spawn_type    - obstacle kind, stable while spawn_valid is high
//   gap_remaining - countdown value (debug)
module obstacle_spawn_scheduler
  import dino_pkg::*;
#(
  parameter int         GAP_W   = 9,
  parameter int         MIN_GAP = 120,
  parameter logic [7:0] SEED    = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             game_tick,
  input  logic             run,
  input  logic [1:0]       speed,
  input  logic             spawn_ready,
  output logic             spawn_valid,
  output logic [1:0]       spawn_type,
  output logic [GAP_W-1:0] gap_remaining
);

  // Wide enough that neither MIN_GAP nor a full 8-bit LFSR value wraps
  // before the saturation compare.
  localparam int SUM_W = ((GAP_W > 8) ? GAP_W : 8) + 1;
  localparam logic [GAP_W-1:0] GAP_MAX = '1;

  spawn_state_t     r_state, w_nxt;
  logic [GAP_W-1:0] r_cnt;
  logic             r_valid;
  logic [1:0]       r_type;

  logic [7:0]       w_lfsr;
  logic             w_adv;
  logic [7:0]       w_shift;
  logic [SUM_W-1:0] w_sum;
  logic [GAP_W-1:0] w_gap;

  lfsr8_galois u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (w_adv),
    .seed  (SEED),
    .q     (w_lfsr)
  );

  // Gap from the pre-advance LFSR value; saturating add keeps it in range.
  // MIN_GAP >= 1 guarantees a non-zero gap.
  assign w_shift = w_lfsr >> speed;
  assign w_sum   = SUM_W'(MIN_GAP) + SUM_W'(w_shift);
  assign w_gap   = (w_sum > SUM_W'(GAP_MAX)) ? GAP_MAX : w_sum[GAP_W-1:0];

  // LFSR steps only on a LOAD that actually commits (run still high).
  assign w_adv = (r_state == ST_LOAD) && run;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_nxt = ST_LOAD;
      ST_LOAD:  w_nxt = ST_COUNT;
      ST_COUNT: if (game_tick && r_cnt == GAP_W'(1)) w_nxt = ST_SPAWN;
      ST_SPAWN: if (spawn_ready) w_nxt = ST_LOAD;
      default:  w_nxt = ST_IDLE;
    endcase
    // run low wins in every state, including a same-cycle handshake.
    if (!run) w_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_type  <= TYPE_CACTUS_SMALL;
    end else begin
      r_state <= w_nxt;
      case (r_state)
        ST_IDLE: begin
          r_cnt   <= '0;
          r_valid <= 1'b0;
        end
        // Ticks in LOAD are deliberately dropped.
        ST_LOAD: begin
          r_cnt  <= w_gap;
          r_type <= w_lfsr[1:0];
        end
        ST_COUNT: begin
          if (game_tick) begin
            if (r_cnt == GAP_W'(1)) begin
              r_cnt   <= '0;
              r_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt - GAP_W'(1);
            end
          end
        end
        // Ticks in SPAWN are not banked; the counter stays at 0.
        ST_SPAWN: if (spawn_ready) r_valid <= 1'b0;
        default: begin
          r_cnt   <= '0;
          r_valid <= 1'b0;
        end
      endcase
      // Abort: type is left as-is, LFSR is untouched (w_adv is low).
      if (!run) begin
        r_cnt   <= '0;
        r_valid <= 1'b0;
      end
    end
  end

  assign spawn_valid   = r_valid;
  assign spawn_type    = r_type;
  assign gap_remaining = r_cnt;

endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// tb_obstacle_spawn_scheduler: directed checks of the spawn scheduler.
// u_dut runs defaults (MIN_GAP 120, SEED A5); u_sat uses MIN_GAP 400,
// SEED FF to hit gap saturation. Both share the same inputs.
module tb_obstacle_spawn_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       game_tick;
  logic       run;
  logic [1:0] speed;
  logic       spawn_ready;

  logic       spawn_valid, s_valid;
  logic [1:0] spawn_type, s_type;
  logic [8:0] gap_remaining, s_gap;
  logic [7:0] lfsr_q;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  obstacle_spawn_scheduler u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .game_tick     (game_tick),
    .run           (run),
    .speed         (speed),
    .spawn_ready   (spawn_ready),
    .spawn_valid   (spawn_valid),
    .spawn_type    (spawn_type),
    .gap_remaining (gap_remaining)
  );

  obstacle_spawn_scheduler #(.GAP_W(9), .MIN_GAP(400), .SEED(8'hFF)) u_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .game_tick     (game_tick),
    .run           (run),
    .speed         (speed),
    .spawn_ready   (spawn_ready),
    .spawn_valid   (s_valid),
    .spawn_type    (s_type),
    .gap_remaining (s_gap)
  );

  assign lfsr_q = u_dut.u_lfsr.q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Count an n-tick gap with a tick every cycle; ends one cycle after spawn.
  task automatic count_out(input int n, input logic [1:0] typ, input string tag);
    game_tick = 1'b1;
    repeat (n - 1) cyc();
    chk({tag, "_last_cnt"}, gap_remaining, 1);
    chk({tag, "_pre_vld"}, spawn_valid, 0);
    cyc();
    chk({tag, "_vld"}, spawn_valid, 1);
    chk({tag, "_cnt0"}, gap_remaining, 0);
    chk({tag, "_type"}, spawn_type, typ);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; game_tick = 1'b0; speed = 2'd0; spawn_ready = 1'b0;
    repeat (3) cyc();

    // Reset state
    chk("rst_vld", spawn_valid, 0);
    chk("rst_type", spawn_type, 0);
    chk("rst_gap", gap_remaining, 0);
    chk("rst_lfsr", lfsr_q, 8'hA5);
    chk("rst_sat_gap", s_gap, 0);
    rst_n = 1'b1;
    cyc();
    chk("idle_gap", gap_remaining, 0);

    // First gap, speed 0: 120 + 165 = 285, type 01, LFSR -> EA
    run = 1'b1;
    cyc();
    chk("load_gap0", gap_remaining, 0);
    cyc();
    chk("g1_gap", gap_remaining, 285);
    chk("g1_type", spawn_type, 1);
    chk("g1_lfsr", lfsr_q, 8'hEA);
    // Saturation: 400 + 255 -> 511, type 11
    chk("sat_gap", s_gap, 511);
    chk("sat_type", s_type, 3);
    count_out(285, 2'd1, "g1");

    // Backpressure with ticks still arriving
    for (int i = 0; i < 50; i++) begin
      cyc();
      chk("bp_vld", spawn_valid, 1);
      chk("bp_type", spawn_type, 1);
      chk("bp_gap", gap_remaining, 0);
    end

    // Accept; speed 2 sampled at the following LOAD
    game_tick = 1'b0; spawn_ready = 1'b1; speed = 2'd2;
    cyc();
    chk("acc_vld", spawn_valid, 0);
    chk("acc_gap", gap_remaining, 0);
    cyc();
    chk("g2_gap", gap_remaining, 178);
    chk("g2_type", spawn_type, 2);
    chk("g2_lfsr", lfsr_q, 8'h75);

    // Back-to-back with ready held; tick held high through SPAWN and LOAD
    count_out(178, 2'd2, "g2");
    cyc();
    chk("g2_one_cycle", spawn_valid, 0);
    cyc();
    chk("g3_gap", gap_remaining, 149);   // tick in LOAD ignored
    chk("g3_type", spawn_type, 1);
    chk("g3_lfsr", lfsr_q, 8'h82);

    // Abort at 37
    repeat (112) cyc();
    chk("abort_at", gap_remaining, 37);
    run = 1'b0; game_tick = 1'b0;
    cyc();
    chk("abort_gap", gap_remaining, 0);
    chk("abort_vld", spawn_valid, 0);
    chk("abort_type", spawn_type, 1);
    chk("abort_lfsr", lfsr_q, 8'h82);
    cyc();
    chk("abort_idle", gap_remaining, 0);
    run = 1'b1;
    cyc();
    cyc();
    chk("g4_gap", gap_remaining, 152);   // next LFSR value, no reseed
    chk("g4_type", spawn_type, 2);
    chk("g4_lfsr", lfsr_q, 8'h41);

    // run drop in the same cycle as the handshake
    count_out(152, 2'd2, "g4");
    chk("hs_ready", spawn_ready, 1);
    run = 1'b0; game_tick = 1'b0;
    cyc();
    chk("hs_vld", spawn_valid, 0);
    chk("hs_gap", gap_remaining, 0);
    chk("hs_lfsr", lfsr_q, 8'h41);
    cyc();
    chk("hs_noload", gap_remaining, 0);
    chk("hs_lfsr2", lfsr_q, 8'h41);
    run = 1'b1;
    cyc();
    cyc();
    chk("g5_gap", gap_remaining, 136);
    chk("g5_type", spawn_type, 1);

    // Async reset while a spawn is waiting
    spawn_ready = 1'b0;
    count_out(136, 2'd1, "g5");
    game_tick = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", spawn_valid, 0);
    chk("arst_gap", gap_remaining, 0);
    chk("arst_type", spawn_type, 0);
    chk("arst_lfsr", lfsr_q, 8'hA5);

    // Fresh seed at speed 2: 120 + (165 >> 2) = 161
    run = 1'b0;
    cyc();
    rst_n = 1'b1;
    run = 1'b1;
    cyc();
    cyc();
    chk("s2_gap", gap_remaining, 161);
    chk("s2_type", spawn_type, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
